// File: rtl/ieu_issue_stage.sv
// Integer execution unit issue stage: captures decoded ALU ops, selects operands,
// holds the op in the EX register that drives the ALU, and hands the result to
// writeback. A one-entry skid buffer lets in_ready come straight from a flop.

package pipeline;
    localparam int XLEN = 32;
endpackage

module ieu_issue_stage
    import pipeline::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_funct3,
    input  logic [6:0]            in_funct7,
    input  logic [1:0]            in_op1_sel,
    input  logic                  in_op2_sel,
    input  logic [XLEN-1:0]       in_rs1_data,
    input  logic [XLEN-1:0]       in_rs2_data,
    input  logic [XLEN-1:0]       in_imm,
    input  logic [XLEN-1:0]       in_pc,
    input  logic [REG_ADDR_W-1:0] in_rd,
    output logic [2:0]            alu_funct3,
    output logic [6:0]            alu_funct7,
    output logic [XLEN-1:0]       alu_operand_1,
    output logic [XLEN-1:0]       alu_operand_2,
    input  logic [XLEN-1:0]       alu_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_result,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [XLEN-1:0]       out_pc
);

    typedef struct packed {
        logic [2:0]            funct3;
        logic [6:0]            funct7;
        logic [XLEN-1:0]       op1;
        logic [XLEN-1:0]       op2;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       pc;
    } payload_t;

    logic     ex_valid_q, ex_valid_d;
    logic     sk_valid_q, sk_valid_d;
    payload_t ex_q, ex_d;
    payload_t sk_q, sk_d;
    payload_t in_pl;

    logic in_fire;
    logic out_fire;
    logic ex_free;

    assign in_ready = !sk_valid_q;
    assign out_valid = ex_valid_q;
    assign in_fire = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign ex_free = !ex_valid_q | out_fire;

    // Capture-side operand selection and funct7 cleanup. Immediate ops carry
    // immediate bits in instr[31:25]; only shift-right-immediate needs them.
    always_comb begin
        in_pl        = '0;
        in_pl.funct3 = in_funct3;
        in_pl.rd     = in_rd;
        in_pl.pc     = in_pc;
        case (in_op1_sel)
            2'b00:   in_pl.op1 = in_rs1_data;
            2'b01:   in_pl.op1 = in_pc;
            default: in_pl.op1 = '0;
        endcase
        in_pl.op2 = in_op2_sel ? in_imm : in_rs2_data;
        if (in_op2_sel && (in_funct3 != 3'b101)) begin
            in_pl.funct7 = 7'b0;
        end else begin
            in_pl.funct7 = in_funct7;
        end
    end

    // Next state for EX and skid; flush overrides everything, the skid always
    // refills EX before a new input so ops leave in acceptance order.
    always_comb begin
        ex_valid_d = ex_valid_q;
        sk_valid_d = sk_valid_q;
        ex_d       = ex_q;
        sk_d       = sk_q;
        if (flush) begin
            ex_valid_d = 1'b0;
            sk_valid_d = 1'b0;
        end else begin
            if (ex_free) begin
                if (sk_valid_q) begin
                    ex_d       = sk_q;
                    ex_valid_d = 1'b1;
                    sk_valid_d = 1'b0;
                end else if (in_fire) begin
                    ex_d       = in_pl;
                    ex_valid_d = 1'b1;
                end else begin
                    ex_valid_d = 1'b0;
                end
            end
            if (in_fire && !ex_free) begin
                sk_d       = in_pl;
                sk_valid_d = 1'b1;
            end
        end
    end

    // State registers; reset clears valids and payloads so the ALU sees zeros.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_q <= 1'b0;
            sk_valid_q <= 1'b0;
            ex_q       <= '0;
            sk_q       <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            sk_valid_q <= sk_valid_d;
            ex_q       <= ex_d;
            sk_q       <= sk_d;
        end
    end

    assign alu_funct3    = ex_q.funct3;
    assign alu_funct7    = ex_q.funct7;
    assign alu_operand_1 = ex_q.op1;
    assign alu_operand_2 = ex_q.op2;
    assign out_result    = alu_result;
    assign out_rd        = ex_q.rd;
    assign out_pc        = ex_q.pc;

endmodule
